axi_wr_arbiter: RTL
===================

Name: axi_wr_arbiter

Overview:
- 2:1 round-robin arbiter that lets two on-chip write masters (m0, m1) share one AXI write port (AW/W/B) toward DRAM.
- Handles one burst at a time. AW is registered. The W channel is locked to the AW winner until the last beat. B is routed back to the owner.
- The arbiter regenerates wlast from a beat counter and flags any master whose wlast disagrees with awlen.

Parameters:
- ADDR_WIDTH, `AXI_ADDR_WIDTH, AW address width.
- DATA_WIDTH, `AXI_DATA_WIDTH, W data width; strobe width is DATA_WIDTH/8.
- ID_WIDTH, `AXI_ID_WIDTH, AXI ID width.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst_n  in  1  reset. The block has one clock; reset is asynchronous and active-low.
- mN_awvalid in 1 / mN_awready out 1 / mN_awid in ID_WIDTH / mN_awaddr in ADDR_WIDTH / mN_awlen in 4 / mN_awsize in 3 / mN_awburst in 2  master N AW, N=0,1.
- mN_wvalid in 1 / mN_wready out 1 / mN_wdata in DATA_WIDTH / mN_wstrb in DATA_WIDTH/8 / mN_wlast in 1  master N W.
- mN_bvalid out 1 / mN_bready in 1 / mN_bid out ID_WIDTH / mN_bresp out 2  master N B.
- s_awvalid out 1 / s_awready in 1 / s_awid out ID_WIDTH / s_awaddr out ADDR_WIDTH / s_awlen out 4 / s_awsize out 3 / s_awburst out 2  DRAM-side AW.
- s_wvalid out 1 / s_wready in 1 / s_wid out ID_WIDTH / s_wdata out DATA_WIDTH / s_wstrb out DATA_WIDTH/8 / s_wlast out 1  DRAM-side W.
- s_bvalid in 1 / s_bready out 1 / s_bid in ID_WIDTH / s_bresp in 2  DRAM-side B.
- err_wlast  out  1  one-cycle pulse on a wlast mismatch.
- owner  out  1  current/last grant index (debug).

Behaviour:
- Reset (async, any state): FSM=IDLE; priority pointer=m0; owner=0; beat_cnt=0; AW register=0.
  - All valid and ready outputs are 0, err_wlast=0, s_wlast=0, and all data outputs are 0.
- FSM states: IDLE -> AW -> W -> B -> IDLE.
- IDLE:
  - Winner is the only requester when one mN_awvalid is high.
  - When both are high, the winner is the pointer master.
  - mN_awready=1 for the winner only, combinational, in the same cycle. The loser's awready stays 0.
  - On that edge: latch awid/awaddr/awlen/awsize/awburst, set owner=winner, beat_cnt=0, go to AW.
  - With no request, the FSM stays in IDLE and all readies stay 0.
- AW:
  - s_awvalid=1 from the cycle after acceptance, with fields taken from the register. Fields are stable while s_awready=0.
  - On s_awvalid&s_awready go to W.
  - Both mN_wready are 0 in this state; W beats never pass ahead of AW.
- W:
  - s_wvalid=m[owner]_wvalid.
  - m[owner]_wready=s_wready; the non-owner wready is 0.
  - s_wdata/s_wstrb are muxed from the owner (combinational, no added latency).
  - s_wid=latched awid.
  - s_wlast=(beat_cnt==awlen), generated internally.
  - On each handshake, beat_cnt increments (4-bit; awlen=15 gives 16 beats, no wrap beyond).
  - err_wlast=1 for exactly one cycle on a handshake where m[owner]_wlast != s_wlast.
  - On the handshake with s_wlast=1, go to B.
- B:
  - s_bready=m[owner]_bready.
  - m[owner]_bvalid=s_bvalid, with bid/bresp passed through; the non-owner bvalid is 0.
  - On handshake: pointer moves to the other master (!owner), go to IDLE.
- IDLE/AW/W: s_bready=0. A stray s_bvalid is held off, never dropped.
- Fairness: back-to-back requests from both masters alternate grants strictly. A single requester may be granted every burst.
- Minimum burst cost: 1 cycle IDLE + 1 AW + (awlen+1) W + 1 B cycles.
- awsize/awburst are forwarded unchanged and not checked.

Test Plan:
- Single master: m0 AW addr=0x1000, len=3, 4 beats with wlast on beat 3, s_awready/s_wready tied 1, bresp=0 → s_awvalid 1 cycle after acceptance; 4 s_w beats with s_wlast only on the 4th; m0_bvalid pulses; err_wlast stays 0.
- Contention: m0 and m1 assert awvalid in the same cycle after reset, each len=0 → m0 is granted first, m1 is granted next; m1 is never accepted while m0's B is pending.
- Contention repeated: both masters request continuously for 6 bursts → grant order is 0,1,0,1,0,1.
- Backpressure: s_awready low for 3 cycles, then s_wready toggling 1,0,1,0 → s_aw fields stay stable; m0_wready mirrors s_wready; no beat is lost or duplicated; m1_wready stays 0.
- wlast error: len=1 with master wlast on beat 0 and again on beat 1 → err_wlast pulses on beat 0; s_wlast is asserted only on beat 1.
- Reset mid-W: rst_n low during beat 2 of len=7 → all outputs are 0 immediately (asynchronous); after release the FSM is in IDLE, the pointer is m0, and a new burst completes normally.

Source files
------------

// File: rtl/axi_wr_arbiter.sv
// ---------------------------------------------------------------------------
// axi_wr_arbiter
//
// Two write masters (m0, m1) share one AXI write port toward DRAM. One burst
// is in flight at a time:
//   IDLE : pick a winner (single requester, or the round-robin pointer when
//          both request), accept its AW combinationally and latch it.
//   AW   : present the latched AW on the DRAM side until s_awready.
//   W    : the W channel is locked to the owner. s_wlast is generated from
//          an internal beat counter. The master's own wlast is only compared
//          against it, and err_wlast pulses on disagreement.
//   B    : route the response back to the owner, then hand priority to the
//          other master.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   mN_aw*  (N=0,1)            master AW: valid/ready/id/addr/len/size/burst
//   mN_w*                      master W : valid/ready/data/strb/last
//   mN_b*                      master B : valid/ready/id/resp
//   s_aw*, s_w*, s_b*          DRAM-side AW/W/B (s_wid carries the burst id)
//   err_wlast                  one-cycle pulse on a master wlast mismatch
//   owner                      current / last granted master index
// ---------------------------------------------------------------------------
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

module axi_wr_arbiter #(
    parameter int ADDR_WIDTH = `AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH = `AXI_DATA_WIDTH,
    parameter int ID_WIDTH   = `AXI_ID_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,

    // master 0
    input  logic                      m0_awvalid,
    output logic                      m0_awready,
    input  logic [ID_WIDTH-1:0]       m0_awid,
    input  logic [ADDR_WIDTH-1:0]     m0_awaddr,
    input  logic [3:0]                m0_awlen,
    input  logic [2:0]                m0_awsize,
    input  logic [1:0]                m0_awburst,
    input  logic                      m0_wvalid,
    output logic                      m0_wready,
    input  logic [DATA_WIDTH-1:0]     m0_wdata,
    input  logic [DATA_WIDTH/8-1:0]   m0_wstrb,
    input  logic                      m0_wlast,
    output logic                      m0_bvalid,
    input  logic                      m0_bready,
    output logic [ID_WIDTH-1:0]       m0_bid,
    output logic [1:0]                m0_bresp,

    // master 1
    input  logic                      m1_awvalid,
    output logic                      m1_awready,
    input  logic [ID_WIDTH-1:0]       m1_awid,
    input  logic [ADDR_WIDTH-1:0]     m1_awaddr,
    input  logic [3:0]                m1_awlen,
    input  logic [2:0]                m1_awsize,
    input  logic [1:0]                m1_awburst,
    input  logic                      m1_wvalid,
    output logic                      m1_wready,
    input  logic [DATA_WIDTH-1:0]     m1_wdata,
    input  logic [DATA_WIDTH/8-1:0]   m1_wstrb,
    input  logic                      m1_wlast,
    output logic                      m1_bvalid,
    input  logic                      m1_bready,
    output logic [ID_WIDTH-1:0]       m1_bid,
    output logic [1:0]                m1_bresp,

    // DRAM side
    output logic                      s_awvalid,
    input  logic                      s_awready,
    output logic [ID_WIDTH-1:0]       s_awid,
    output logic [ADDR_WIDTH-1:0]     s_awaddr,
    output logic [3:0]                s_awlen,
    output logic [2:0]                s_awsize,
    output logic [1:0]                s_awburst,
    output logic                      s_wvalid,
    input  logic                      s_wready,
    output logic [ID_WIDTH-1:0]       s_wid,
    output logic [DATA_WIDTH-1:0]     s_wdata,
    output logic [DATA_WIDTH/8-1:0]   s_wstrb,
    output logic                      s_wlast,
    input  logic                      s_bvalid,
    output logic                      s_bready,
    input  logic [ID_WIDTH-1:0]       s_bid,
    input  logic [1:0]                s_bresp,

    output logic                      err_wlast,
    output logic                      owner
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } state_t;

    state_t state_reg, state_next;

    // -----------------------------------------------------------------------
    // Per-master views, indexed by master number
    // -----------------------------------------------------------------------
    logic [1:0]            aw_valid;
    logic [1:0]            w_valid;
    logic [1:0]            w_last;
    logic [1:0]            b_ready;
    logic [ID_WIDTH-1:0]   aw_id    [2];
    logic [ADDR_WIDTH-1:0] aw_addr  [2];
    logic [3:0]            aw_len   [2];
    logic [2:0]            aw_size  [2];
    logic [1:0]            aw_burst [2];
    logic [DATA_WIDTH-1:0] w_data   [2];
    logic [STRB_WIDTH-1:0] w_strb   [2];

    logic [1:0]            aw_ready;
    logic [1:0]            w_ready;
    logic [1:0]            b_valid;
    logic [ID_WIDTH-1:0]   b_id     [2];
    logic [1:0]            b_resp   [2];

    assign aw_valid    = {m1_awvalid, m0_awvalid};
    assign w_valid     = {m1_wvalid,  m0_wvalid};
    assign w_last      = {m1_wlast,   m0_wlast};
    assign b_ready     = {m1_bready,  m0_bready};
    assign aw_id[0]    = m0_awid;
    assign aw_id[1]    = m1_awid;
    assign aw_addr[0]  = m0_awaddr;
    assign aw_addr[1]  = m1_awaddr;
    assign aw_len[0]   = m0_awlen;
    assign aw_len[1]   = m1_awlen;
    assign aw_size[0]  = m0_awsize;
    assign aw_size[1]  = m1_awsize;
    assign aw_burst[0] = m0_awburst;
    assign aw_burst[1] = m1_awburst;
    assign w_data[0]   = m0_wdata;
    assign w_data[1]   = m1_wdata;
    assign w_strb[0]   = m0_wstrb;
    assign w_strb[1]   = m1_wstrb;

    assign m0_awready  = aw_ready[0];
    assign m1_awready  = aw_ready[1];
    assign m0_wready   = w_ready[0];
    assign m1_wready   = w_ready[1];
    assign m0_bvalid   = b_valid[0];
    assign m1_bvalid   = b_valid[1];
    assign m0_bid      = b_id[0];
    assign m1_bid      = b_id[1];
    assign m0_bresp    = b_resp[0];
    assign m1_bresp    = b_resp[1];

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic                  ptr_reg;        // master favoured on a tie
    logic                  owner_reg;
    logic [3:0]            beat_cnt_reg;
    logic [ID_WIDTH-1:0]   aw_id_reg;
    logic [ADDR_WIDTH-1:0] aw_addr_reg;
    logic [3:0]            aw_len_reg;
    logic [2:0]            aw_size_reg;
    logic [1:0]            aw_burst_reg;

    // -----------------------------------------------------------------------
    // Arbitration and handshake terms
    // -----------------------------------------------------------------------
    logic req_any;
    logic winner;
    logic aw_accept;
    logic last_beat;
    logic w_hs;
    logic b_hs;

    assign req_any   = |aw_valid;
    // With a single requester, aw_valid[1] alone names it; on a tie the
    // round-robin pointer decides.
    assign winner    = (aw_valid == 2'b11) ? ptr_reg : aw_valid[1];
    assign aw_accept = (state_reg == ST_IDLE) && req_any;
    assign last_beat = (beat_cnt_reg == aw_len_reg);
    assign w_hs      = (state_reg == ST_W) && w_valid[owner_reg] && s_wready;
    assign b_hs      = (state_reg == ST_B) && s_bvalid && b_ready[owner_reg];

    // Per-master return paths: only the owner ever sees a ready/valid.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            localparam logic IDX = 1'(gi);
            logic is_owner;

            assign is_owner = (owner_reg == IDX);

            // awready is combinational from awvalid; it is held low while
            // reset is asserted so a master still requesting during reset
            // never sees a grant.
            assign aw_ready[gi] = rst_n && aw_accept && (winner == IDX);
            assign w_ready[gi]  = (state_reg == ST_W) && is_owner && s_wready;
            assign b_valid[gi]  = (state_reg == ST_B) && is_owner && s_bvalid;
            assign b_id[gi]     = ((state_reg == ST_B) && is_owner) ? s_bid   : '0;
            assign b_resp[gi]   = ((state_reg == ST_B) && is_owner) ? s_bresp : 2'b00;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (req_any)             state_next = ST_AW;
            ST_AW:   if (s_awready)           state_next = ST_W;
            ST_W:    if (w_hs && last_beat)   state_next = ST_B;
            ST_B:    if (b_hs)                state_next = ST_IDLE;
            default:                          state_next = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wlast   = 1'b0;
        s_bready  = 1'b0;
        err_wlast = 1'b0;
        case (state_reg)
            ST_AW: begin
                s_awvalid = 1'b1;
            end
            ST_W: begin
                s_wvalid  = w_valid[owner_reg];
                s_wdata   = w_data[owner_reg];
                s_wstrb   = w_strb[owner_reg];
                s_wlast   = last_beat;
                // The master's wlast never steers the burst; it is only
                // cross-checked against the counter-derived s_wlast.
                err_wlast = w_hs && (w_last[owner_reg] != last_beat);
            end
            ST_B: begin
                // Any s_bvalid outside this state is held off, not dropped.
                s_bready  = b_ready[owner_reg];
            end
            default: ;
        endcase
    end

    // The AW register feeds the DRAM side directly, so the fields cannot
    // move while s_awready is low.
    assign s_awid    = aw_id_reg;
    assign s_awaddr  = aw_addr_reg;
    assign s_awlen   = aw_len_reg;
    assign s_awsize  = aw_size_reg;
    assign s_awburst = aw_burst_reg;
    assign s_wid     = aw_id_reg;
    assign owner     = owner_reg;

    // -----------------------------------------------------------------------
    // Datapath registers: AW latch, owner, beat counter, priority pointer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg      <= 1'b0;
            owner_reg    <= 1'b0;
            beat_cnt_reg <= 4'd0;
            aw_id_reg    <= '0;
            aw_addr_reg  <= '0;
            aw_len_reg   <= 4'd0;
            aw_size_reg  <= 3'd0;
            aw_burst_reg <= 2'd0;
        end else begin
            if (aw_accept) begin
                owner_reg    <= winner;
                beat_cnt_reg <= 4'd0;
                aw_id_reg    <= aw_id[winner];
                aw_addr_reg  <= aw_addr[winner];
                aw_len_reg   <= aw_len[winner];
                aw_size_reg  <= aw_size[winner];
                aw_burst_reg <= aw_burst[winner];
            end
            // Counter stops on the last beat, so awlen=15 never wraps.
            if (w_hs && !last_beat) begin
                beat_cnt_reg <= beat_cnt_reg + 4'd1;
            end
            // Priority passes to the other master once the burst retires.
            if (b_hs) begin
                ptr_reg <= ~owner_reg;
            end
        end
    end

endmodule
